// File: rtl/ecc_err_monitor.sv
// ---------------------------------------------------------------------------
// ecc_err_monitor
// Collects error status from an upstream ECC fault-detect stage. It counts
// single-bit, double-bit and dual-decoder-mismatch events, captures the
// address and type of the first event since the last clear, and raises a
// sticky interrupt.
//
// Ports
//   clk          : single clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   chk_vld      : qualifies chk_addr / sbit_err / dbit_err / ecc_fault
//   chk_addr     : address of the word just decoded
//   sbit_err     : corrected single-bit error
//   dbit_err     : uncorrectable double-bit error
//   ecc_fault    : dual-decoder mismatch
//   sbit_thresh  : single-bit interrupt threshold, 0 disables it
//   clr_req      : one-cycle pulse clearing all logged state
//   sbit_cnt     : saturating single-bit event counter
//   dbit_cnt     : saturating double-bit event counter
//   fault_cnt    : saturating fault event counter
//   first_addr   : address of the first logged event
//   first_type   : 01 sbit, 10 dbit, 11 fault, 00 nothing logged
//   err_irq      : sticky level interrupt
//   clr_ack      : one-cycle acknowledge, the cycle after clr_req
// ---------------------------------------------------------------------------
module ecc_err_monitor #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chk_vld,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  input  logic [CNT_WIDTH-1:0]  sbit_thresh,
  input  logic                  clr_req,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] first_addr,
  output logic [1:0]            first_type,
  output logic                  err_irq,
  output logic                  clr_ack
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOGGED = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_sbit_cnt;
  logic [CNT_WIDTH-1:0]  r_dbit_cnt;
  logic [CNT_WIDTH-1:0]  r_fault_cnt;
  logic [ADDR_WIDTH-1:0] r_first_addr;
  logic [1:0]            r_first_type;
  logic                  r_err_irq;
  logic                  r_clr_ack;

  logic                  w_sbit_ev;
  logic                  w_dbit_ev;
  logic                  w_fault_ev;
  logic                  w_any_ev;
  logic [CNT_WIDTH-1:0]  w_sbit_base;
  logic [CNT_WIDTH-1:0]  w_dbit_base;
  logic [CNT_WIDTH-1:0]  w_fault_base;
  logic                  w_irq_base;
  logic                  w_empty_base;
  logic [CNT_WIDTH-1:0]  w_sbit_inc;
  logic                  w_thr_hit;
  logic [1:0]            w_ev_type;

  // Saturating increment: an all-ones counter stays at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Event classification; a dbit event masks sbit_err in the same cycle.
  assign w_sbit_ev  = chk_vld & sbit_err & ~dbit_err;
  assign w_dbit_ev  = chk_vld & dbit_err;
  assign w_fault_ev = chk_vld & ecc_fault;
  assign w_any_ev   = w_sbit_ev | w_dbit_ev | w_fault_ev;

  // Clear-adjusted starting point: a coincident event lands on top of the clear.
  always_comb begin
    w_sbit_base  = r_sbit_cnt;
    w_dbit_base  = r_dbit_cnt;
    w_fault_base = r_fault_cnt;
    w_irq_base   = r_err_irq;
    w_empty_base = (r_state == ST_EMPTY);
    if (clr_req) begin
      w_sbit_base  = {CNT_WIDTH{1'b0}};
      w_dbit_base  = {CNT_WIDTH{1'b0}};
      w_fault_base = {CNT_WIDTH{1'b0}};
      w_irq_base   = 1'b0;
      w_empty_base = 1'b1;
    end else begin
      w_empty_base = (r_state == ST_EMPTY);
    end
  end

  // Threshold compares against the post-increment count using the current threshold.
  assign w_sbit_inc = sat_inc(w_sbit_base);
  assign w_thr_hit  = w_sbit_ev && (sbit_thresh != {CNT_WIDTH{1'b0}}) &&
                      (w_sbit_inc >= sbit_thresh);

  // First-event type priority: fault > dbit > sbit.
  always_comb begin
    w_ev_type = 2'b00;
    case ({w_fault_ev, w_dbit_ev, w_sbit_ev})
      3'b100, 3'b101, 3'b110, 3'b111: w_ev_type = 2'b11;
      3'b010, 3'b011:                 w_ev_type = 2'b10;
      3'b001:                         w_ev_type = 2'b01;
      default:                        w_ev_type = 2'b00;
    endcase
  end

  // Monitor FSM with counters, first-event capture, interrupt and clear ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_sbit_cnt   <= {CNT_WIDTH{1'b0}};
      r_dbit_cnt   <= {CNT_WIDTH{1'b0}};
      r_fault_cnt  <= {CNT_WIDTH{1'b0}};
      r_first_addr <= {ADDR_WIDTH{1'b0}};
      r_first_type <= 2'b00;
      r_err_irq    <= 1'b0;
      r_clr_ack    <= 1'b0;
    end else begin
      r_sbit_cnt  <= w_sbit_ev  ? w_sbit_inc             : w_sbit_base;
      r_dbit_cnt  <= w_dbit_ev  ? sat_inc(w_dbit_base)   : w_dbit_base;
      r_fault_cnt <= w_fault_ev ? sat_inc(w_fault_base)  : w_fault_base;
      r_err_irq   <= w_irq_base | w_dbit_ev | w_fault_ev | w_thr_hit;
      r_clr_ack   <= clr_req;
      if (w_empty_base && w_any_ev) begin
        r_state      <= ST_LOGGED;
        r_first_addr <= chk_addr;
        r_first_type <= w_ev_type;
      end else if (clr_req) begin
        r_state      <= ST_EMPTY;
        r_first_addr <= {ADDR_WIDTH{1'b0}};
        r_first_type <= 2'b00;
      end else begin
        r_state      <= r_state;
        r_first_addr <= r_first_addr;
        r_first_type <= r_first_type;
      end
    end
  end

  assign sbit_cnt   = r_sbit_cnt;
  assign dbit_cnt   = r_dbit_cnt;
  assign fault_cnt  = r_fault_cnt;
  assign first_addr = r_first_addr;
  assign first_type = r_first_type;
  assign err_irq    = r_err_irq;
  assign clr_ack    = r_clr_ack;

endmodule

// File: tb/tb_ecc_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_ecc_err_monitor
// Directed, table-driven bench for ecc_err_monitor. A 16-bit-counter
// instance runs the vector table and the reset sequence; a 4-bit-counter
// instance on the same stimulus is used for the saturation check.
// ---------------------------------------------------------------------------
module tb_ecc_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        chk_vld;
  logic [7:0]  chk_addr;
  logic        sbit_err;
  logic        dbit_err;
  logic        ecc_fault;
  logic [15:0] sbit_thresh;
  logic [3:0]  sbit_thresh4;
  logic        clr_req;

  logic [15:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [7:0]  first_addr;
  logic [1:0]  first_type;
  logic        err_irq, clr_ack;

  logic [3:0]  sbit_cnt4, dbit_cnt4, fault_cnt4;
  logic [7:0]  first_addr4;
  logic [1:0]  first_type4;
  logic        err_irq4, clr_ack4;

  int checks = 0;
  int errors = 0;

  ecc_err_monitor #(.ADDR_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .chk_vld(chk_vld), .chk_addr(chk_addr),
    .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .sbit_thresh(sbit_thresh), .clr_req(clr_req),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .first_addr(first_addr), .first_type(first_type),
    .err_irq(err_irq), .clr_ack(clr_ack)
  );

  ecc_err_monitor #(.ADDR_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .chk_vld(chk_vld), .chk_addr(chk_addr),
    .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .sbit_thresh(sbit_thresh4), .clr_req(clr_req),
    .sbit_cnt(sbit_cnt4), .dbit_cnt(dbit_cnt4), .fault_cnt(fault_cnt4),
    .first_addr(first_addr4), .first_type(first_type4),
    .err_irq(err_irq4), .clr_ack(clr_ack4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  addr;
    logic        s, d, f;
    logic [15:0] thr;
    logic        clr;
    logic [15:0] e_s, e_d, e_f;
    logic [7:0]  e_fa;
    logic [1:0]  e_ft;
    logic        e_irq, e_ack;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic vld, input logic [7:0] addr,
                              input logic s, input logic d, input logic f,
                              input logic [15:0] thr, input logic clr,
                              input logic [15:0] e_s, input logic [15:0] e_d,
                              input logic [15:0] e_f, input logic [7:0] e_fa,
                              input logic [1:0] e_ft, input logic e_irq,
                              input logic e_ack);
    vec_t v;
    v.vld = vld; v.addr = addr; v.s = s; v.d = d; v.f = f; v.thr = thr;
    v.clr = clr; v.e_s = e_s; v.e_d = e_d; v.e_f = e_f; v.e_fa = e_fa;
    v.e_ft = e_ft; v.e_irq = e_irq; v.e_ack = e_ack;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_s, input logic [15:0] e_d,
                           input logic [15:0] e_f, input logic [7:0] e_fa,
                           input logic [1:0] e_ft, input logic e_irq, input logic e_ack);
    check({tag, ".sbit_cnt"},   {16'd0, sbit_cnt},   {16'd0, e_s});
    check({tag, ".dbit_cnt"},   {16'd0, dbit_cnt},   {16'd0, e_d});
    check({tag, ".fault_cnt"},  {16'd0, fault_cnt},  {16'd0, e_f});
    check({tag, ".first_addr"}, {24'd0, first_addr}, {24'd0, e_fa});
    check({tag, ".first_type"}, {30'd0, first_type}, {30'd0, e_ft});
    check({tag, ".err_irq"},    {31'd0, err_irq},    {31'd0, e_irq});
    check({tag, ".clr_ack"},    {31'd0, clr_ack},    {31'd0, e_ack});
  endtask

  task automatic drive(input logic vld, input logic [7:0] addr, input logic s,
                       input logic d, input logic f, input logic [15:0] thr,
                       input logic clr);
    chk_vld = vld; chk_addr = addr; sbit_err = s; dbit_err = d;
    ecc_fault = f; sbit_thresh = thr; clr_req = clr;
  endtask

  initial begin
    // Table: each row is one cycle of stimulus and the outputs expected after that edge.
    vecs[0]  = mk(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd1, 16'd0, 16'd0, 8'h12, 2'b01, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 16'd0,  1'b0, 16'd1, 16'd0, 16'd0, 8'h12, 2'b01, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd2, 16'd0, 16'd0, 8'h12, 2'b01, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 16'd0,  1'b0, 16'd0, 16'd1, 16'd1, 8'h05, 2'b11, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 16'd0,  1'b1, 16'd1, 16'd0, 16'd0, 8'h33, 2'b01, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 16'd3,  1'b0, 16'd1, 16'd0, 16'd0, 8'h01, 2'b01, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 16'd3,  1'b0, 16'd2, 16'd0, 16'd0, 8'h01, 2'b01, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 16'd3,  1'b0, 16'd3, 16'd0, 16'd0, 8'h01, 2'b01, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 16'd3,  1'b0, 16'd3, 16'd0, 16'd1, 8'h01, 2'b01, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 16'd10, 1'b0, 16'd1, 16'd0, 16'd0, 8'h0A, 2'b01, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 8'h0B, 1'b1, 1'b0, 1'b0, 16'd10, 1'b0, 16'd2, 16'd0, 16'd0, 8'h0A, 2'b01, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1,  1'b0, 16'd2, 16'd0, 16'd0, 8'h0A, 2'b01, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 16'd1,  1'b0, 16'd3, 16'd0, 16'd0, 8'h0A, 2'b01, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      vecs[20+i] = mk(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0, 1'b0, 16'd0, 1'b0,
                      16'(i+1), 16'd0, 16'd0, 8'h70, 2'b01, 1'b0, 1'b0);
    end
    vecs[25] = mk(1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 16'd0,  1'b1, 16'd0, 16'd1, 16'd0, 8'h40, 2'b10, 1'b1, 1'b1);
    vecs[26] = mk(1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 16'd0, 16'd2, 16'd0, 8'h40, 2'b10, 1'b1, 1'b0);
    vecs[27] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b1);
    vecs[28] = mk(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 16'd0,  1'b0, 16'd1, 16'd0, 16'd1, 8'h3C, 2'b11, 1'b1, 1'b0);

    // Reset state.
    rst_n = 1'b0;
    sbit_thresh4 = 4'd0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_hold", 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset_idle", 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b0);

    // Vector table.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].vld, vecs[i].addr, vecs[i].s, vecs[i].d, vecs[i].f, vecs[i].thr, vecs[i].clr);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_s, vecs[i].e_d, vecs[i].e_f,
                vecs[i].e_fa, vecs[i].e_ft, vecs[i].e_irq, vecs[i].e_ack);
    end

    // Async reset between edges while LOGGED with clr_ack high.
    drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    @(posedge clk); #1;
    check_all("pre_rst", 16'd1, 16'd0, 16'd0, 8'h22, 2'b01, 1'b0, 1'b1);
    drive(1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all($sformatf("post_rst_novld%0d", i), 16'd0, 16'd0, 16'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    end
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    check_all("post_rst_first", 16'd1, 16'd0, 16'd0, 8'h12, 2'b01, 1'b0, 1'b0);

    // Saturation: clear, then 20 sbit events; the 4-bit instance must stick at 0xF.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    @(posedge clk); #1;
    check("sat_clr.sbit_cnt4", {28'd0, sbit_cnt4}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'h60, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("sat%0d.sbit_cnt4", i), {28'd0, sbit_cnt4}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    check("sat.sbit_cnt16", {16'd0, sbit_cnt}, 32'd20);
    check("sat.err_irq4", {31'd0, err_irq4}, 32'd0);
    check("sat.first_addr4", {24'd0, first_addr4}, 32'h60);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    check("sat_hold.sbit_cnt4", {28'd0, sbit_cnt4}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_err_monitor.md
ECC_ERR_MONITOR -- requirements
Module: ecc_err_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of the checked-word address.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each error counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port chk_vld  input  1  qualifies the status inputs for the current cycle.
REQ-006 SHALL have port chk_addr  input  ADDR_WIDTH  address of the word just decoded.
REQ-007 SHALL have port sbit_err  input  1  single-bit error corrected, from the upstream ECC fault-detect stage.
REQ-008 SHALL have port dbit_err  input  1  uncorrectable double-bit error, from the same stage.
REQ-009 SHALL have port ecc_fault  input  1  dual-decoder mismatch, from the same stage.
REQ-010 SHALL have port sbit_thresh  input  CNT_WIDTH  single-bit interrupt threshold; 0 disables the threshold.
REQ-011 SHALL have port clr_req  input  1  single-cycle pulse requesting clear of all logged state.
REQ-012 SHALL have port sbit_cnt / dbit_cnt / fault_cnt  output  CNT_WIDTH each  event counters.
REQ-013 SHALL have port first_addr  output  ADDR_WIDTH  address of first logged event.
REQ-014 SHALL have port first_type  output  2  type of first event: 01 sbit, 10 dbit, 11 fault.
REQ-015 SHALL have port err_irq  output  1  level interrupt.
REQ-016 SHALL have port clr_ack  output  1  single-cycle acknowledge of clr_req.

Function
REQ-017 SHALL ignore sbit_err, dbit_err, ecc_fault, chk_addr when chk_vld=0.
REQ-018 SHALL classify a valid cycle: dbit_err=1 -> dbit event (sbit_err ignored that cycle); else sbit_err=1 -> sbit event; ecc_fault=1 -> fault event, independent of and additional to the sbit/dbit classification.
REQ-019 SHALL increment the matching counter by 1 per event, saturating at all-ones (no wrap).
REQ-020 SHALL register all outputs; an event on cycle N is visible on outputs at cycle N+1.
REQ-021 SHALL implement FSM states EMPTY (nothing logged) and LOGGED (first event captured).
REQ-022 EMPTY -> LOGGED on first valid event; first_addr=chk_addr, first_type per priority fault(11) > dbit(10) > sbit(01).
REQ-023 In LOGGED, first_addr/first_type SHALL hold; later events update counters only.
REQ-024 SHALL set err_irq (sticky) on any dbit event, any fault event, or when sbit_thresh!=0 and the post-increment sbit_cnt >= sbit_thresh.
REQ-025 On clr_req=1: counters, first_addr, first_type, err_irq SHALL clear and FSM SHALL go to EMPTY on the next edge; clr_ack=1 for exactly that next cycle.
REQ-026 Event coincident with clr_req SHALL be applied after the clear: its counter reads 1, it is captured as first event, err_irq evaluated for it; FSM ends in LOGGED.
REQ-027 clr_req asserted on consecutive cycles SHALL produce clr_ack on each following cycle; no internal clear-pending state.
REQ-028 Threshold change SHALL take effect on the next sbit event only; no retroactive irq from lowering sbit_thresh.

Reset
REQ-029 rst_n=0 SHALL immediately force FSM=EMPTY, all counters=0, first_addr=0, first_type=00, err_irq=0, clr_ack=0, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL discard all logged state; the first valid cycle after release SHALL behave as from EMPTY.

Verification
REQ-031 Single sbit at addr 0x12, sbit_thresh=0 -> next cycle sbit_cnt=1, first_addr=0x12, first_type=01, err_irq=0.
REQ-032 sbit_err=1 and dbit_err=1 and ecc_fault=1 same valid cycle, addr 0x05 -> dbit_cnt=1, sbit_cnt=0, fault_cnt=1, first_type=11, err_irq=1.
REQ-033 sbit_thresh=3, three sbit events at 0x01,0x02,0x03 -> err_irq rises the cycle after the third; first_addr=0x01.
REQ-034 CNT_WIDTH=4, 20 sbit events -> sbit_cnt stays 0xF, no wrap.
REQ-035 clr_req with coincident dbit at 0x40 while LOGGED with sbit_cnt=5 -> next cycle clr_ack=1, sbit_cnt=0, dbit_cnt=1, first_addr=0x40, first_type=10, err_irq=1.
REQ-036 rst_n pulsed low between clock edges while LOGGED -> all outputs 0 immediately; events with chk_vld=0 after release leave outputs 0.
